// File: rtl/cfi_shadow_stack_sched.sv
// rtl/cfi_shadow_stack_sched.sv - shadow return-address stack scheduler with event FIFO and sticky alarm
module cfi_shadow_stack_sched #(
    parameter int NR_PORTS   = 2,
    parameter int ADDR_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int SS_DEPTH   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         en_i,
    input  logic [NR_PORTS-1:0]          evt_valid_i,
    input  logic [NR_PORTS-1:0]          evt_call_i,
    input  logic [NR_PORTS*ADDR_W-1:0]   evt_addr_i,
    input  logic                         clear_i,
    output logic                         stall_o,
    output logic                         busy_o,
    output logic                         alarm_o,
    output logic [1:0]                   alarm_cause_o,
    output logic                         alarm_fifo_o,
    output logic [ADDR_W-1:0]            alarm_addr_o,
    output logic [$clog2(SS_DEPTH+1)-1:0] ss_ptr_o
);
    localparam int IDX_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W    = $clog2(SS_DEPTH + 1);
    localparam int SS_IDX_W = $clog2(SS_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, ALARM} state_e;
    typedef struct packed {
        logic              call;
        logic [ADDR_W-1:0] addr;
    } evt_t;

    state_e            state_q, state_d;
    evt_t              fifo_q [FIFO_DEPTH];
    logic [ADDR_W-1:0] stack_q [SS_DEPTH];
    logic [IDX_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  ptr_q;
    logic [1:0]        cause_q;
    logic              fifo_flag_q;
    logic [ADDR_W-1:0] alarm_addr_q;

    logic                active, enq_ok, deq;
    logic [CNT_W-1:0]    space, n_enq;
    logic [NR_PORTS-1:0] wr_en;
    logic [IDX_W-1:0]    wr_idx [NR_PORTS];
    logic                ovf;
    logic [ADDR_W-1:0]   ovf_addr;
    evt_t                head;
    logic                push, pop, chk_viol;
    logic [1:0]          chk_cause;
    logic [SS_IDX_W-1:0] top_idx;

    // clear_i wins over everything in its cycle: nothing enters or leaves the FIFO
    assign active = !clear_i && (state_q != ALARM);
    assign enq_ok = active && en_i;
    assign deq    = active && (count_q != '0);
    assign space  = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(deq);

    always_comb begin
        n_enq    = '0;
        wr_en    = '0;
        ovf      = 1'b0;
        ovf_addr = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            wr_idx[p] = '0;
            if (enq_ok && evt_valid_i[p]) begin
                if (n_enq < space) begin
                    wr_en[p]  = 1'b1;
                    wr_idx[p] = wr_ptr_q + n_enq[IDX_W-1:0];
                    n_enq     = n_enq + CNT_W'(1);
                end else if (!ovf) begin
                    ovf      = 1'b1;
                    ovf_addr = evt_addr_i[p*ADDR_W +: ADDR_W];
                end
            end
        end
        count_d = count_q + n_enq - CNT_W'(deq);
    end

    assign head    = fifo_q[rd_ptr_q];
    assign top_idx = SS_IDX_W'(ptr_q - PTR_W'(1));

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        chk_viol  = 1'b0;
        chk_cause = 2'b00;
        if (deq) begin
            if (head.call) begin
                if (ptr_q == PTR_W'(SS_DEPTH)) begin
                    chk_viol  = 1'b1;
                    chk_cause = 2'b10;
                end else begin
                    push = 1'b1;
                end
            end else if (ptr_q == '0) begin
                chk_viol  = 1'b1;
                chk_cause = 2'b11;
            end else if (stack_q[top_idx] == head.addr) begin
                pop = 1'b1;
            end else begin
                chk_viol  = 1'b1;
                chk_cause = 2'b01;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (en_i) state_d = RUN;
            RUN:     if (!en_i && count_q == '0) state_d = IDLE;
            ALARM:   state_d = ALARM;
            default: state_d = IDLE;
        endcase
        if (ovf || chk_viol) state_d = ALARM;
        if (clear_i) begin
            state_d = (state_q == ALARM || (state_q == RUN && !en_i)) ? IDLE : state_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ptr_q        <= '0;
            cause_q      <= 2'b00;
            fifo_flag_q  <= 1'b0;
            alarm_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (clear_i) begin
                rd_ptr_q     <= '0;
                wr_ptr_q     <= '0;
                count_q      <= '0;
                ptr_q        <= '0;
                cause_q      <= 2'b00;
                fifo_flag_q  <= 1'b0;
                alarm_addr_q <= '0;
            end else if (state_q != ALARM) begin
                rd_ptr_q <= rd_ptr_q + IDX_W'(deq);
                wr_ptr_q <= wr_ptr_q + n_enq[IDX_W-1:0];
                count_q  <= count_d;
                if (push)     ptr_q <= ptr_q + PTR_W'(1);
                else if (pop) ptr_q <= ptr_q - PTR_W'(1);
                // a dropped event outranks a check failure in the same cycle
                if (ovf) begin
                    cause_q      <= 2'b11;
                    fifo_flag_q  <= 1'b1;
                    alarm_addr_q <= ovf_addr;
                end else if (chk_viol) begin
                    cause_q      <= chk_cause;
                    fifo_flag_q  <= 1'b0;
                    alarm_addr_q <= head.addr;
                end
            end
        end
    end

    // payload storage carries no reset; occupancy is tracked by count/ptr
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NR_PORTS; p++) begin
            if (wr_en[p]) fifo_q[wr_idx[p]] <= {evt_call_i[p], evt_addr_i[p*ADDR_W +: ADDR_W]};
        end
        if (push) stack_q[SS_IDX_W'(ptr_q)] <= head.addr;
    end

    assign alarm_o       = (state_q == ALARM);
    assign alarm_cause_o = cause_q;
    assign alarm_fifo_o  = fifo_flag_q;
    assign alarm_addr_o  = alarm_addr_q;
    assign busy_o        = (count_q != '0);
    assign ss_ptr_o      = ptr_q;
    assign stall_o       = (state_q != ALARM) && ((CNT_W'(FIFO_DEPTH) - count_q) < CNT_W'(NR_PORTS));

endmodule
